// File: rtl/demoman_pkg.sv
// Shared encodings for the match sequencer: game states, winner codes and
// the default health width.
package demoman_pkg;

    localparam int DEFAULT_HEALTH_W = 3;

    typedef enum logic [2:0] {
        GS_IDLE       = 3'd0,
        GS_COUNTDOWN  = 3'd1,
        GS_FIGHT      = 3'd2,
        GS_KO         = 3'd3,
        GS_MATCH_OVER = 3'd4
    } game_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_e;

endpackage

// File: rtl/match_controller_sec_timer.sv
// Frame counter plus seconds down-counter. 'expired' flags the frame on
// which the last remaining second runs out.
module sec_timer #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int SEC_W          = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEC_W-1:0] load_value,
    input  logic             enable,
    output logic [SEC_W-1:0] seconds,
    output logic             expired
);

    localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);

    logic [FRAME_W-1:0] frame;
    logic               wrap;

    assign wrap    = enable && (frame == FRAME_LAST) && (seconds != '0);
    assign expired = wrap && (seconds == SEC_W'(1));

    // Load wins over counting so a re-arm never loses its first frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame   <= '0;
            seconds <= '0;
        end else if (load) begin
            frame   <= '0;
            seconds <= load_value;
        end else if (enable && (seconds != '0)) begin
            if (wrap) begin
                frame   <= '0;
                seconds <= seconds - SEC_W'(1);
            end else begin
                frame   <= frame + FRAME_W'(1);
            end
        end
    end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: countdown, fight, KO hold and match end.
// Define MATCH_ROUND_TIMER_EN to enable the round time limit.
module match_controller
    import demoman_pkg::*;
#(
    parameter int FRAMES_PER_SEC    = 60,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int ROUND_SECONDS     = 99,
    parameter int KO_FRAMES         = 120,
    parameter int ROUNDS_TO_WIN     = 2,
    parameter int HEALTH_W          = DEFAULT_HEALTH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [HEALTH_W-1:0] player1_health,
    input  logic [HEALTH_W-1:0] player2_health,
    output logic [2:0]          game_state,
    output logic                freeze,
    output logic                round_reset,
    output logic [3:0]          countdown_digit,
    output logic [6:0]          round_timer,
    output logic [1:0]          p1_wins,
    output logic [1:0]          p2_wins,
    output logic [1:0]          winner
);

    localparam int KO_W = $clog2(KO_FRAMES + 1);
    localparam logic [KO_W-1:0] KO_LAST     = KO_W'(KO_FRAMES - 1);
    localparam logic [1:0]      WINS_TARGET = 2'(ROUNDS_TO_WIN);

    game_state_e     state_q, state_d;
    winner_e         winner_q, winner_d;
    logic            start_q, start_edge;
    logic            round_reset_d;
    logic            clear_wins, p1_inc, p2_inc, set_winner;
    logic            p1_ko, p2_ko, ko_any;
    logic            cd_expired, rt_expired;
    logic [KO_W-1:0] ko_cnt;

    assign start_edge = start & ~start_q;
    assign p1_ko      = (player1_health == '0);
    assign p2_ko      = (player2_health == '0);
    assign game_state = state_q;
    assign winner     = winner_q;

    // Every entry into COUNTDOWN coincides with a round_reset pulse.
    sec_timer #(.FRAMES_PER_SEC(FRAMES_PER_SEC), .SEC_W(4)) u_countdown (
        .clk        (clk),
        .rst        (rst),
        .load       (round_reset_d),
        .load_value (4'(COUNTDOWN_SECONDS)),
        .enable     (state_q == GS_COUNTDOWN),
        .seconds    (countdown_digit),
        .expired    (cd_expired)
    );

`ifdef MATCH_ROUND_TIMER_EN
    logic rt_load, rt_enable;
    assign rt_load   = (state_q == GS_COUNTDOWN) && cd_expired;
    // Freeze the display on a KO frame so it shows the time left at the KO.
    assign rt_enable = (state_q == GS_FIGHT) && !ko_any;

    sec_timer #(.FRAMES_PER_SEC(FRAMES_PER_SEC), .SEC_W(7)) u_round_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (rt_load),
        .load_value (7'(ROUND_SECONDS)),
        .enable     (rt_enable),
        .seconds    (round_timer),
        .expired    (rt_expired)
    );
`else
    assign rt_expired  = 1'b0;
    assign round_timer = '0;
`endif

    always_comb begin
        state_d       = state_q;
        round_reset_d = 1'b0;
        clear_wins    = 1'b0;
        p1_inc        = 1'b0;
        p2_inc        = 1'b0;
        set_winner    = 1'b0;
        winner_d      = WIN_NONE;
        ko_any        = 1'b0;
        case (state_q)
            GS_IDLE, GS_MATCH_OVER: begin
                if (start_edge) begin
                    state_d       = GS_COUNTDOWN;
                    round_reset_d = 1'b1;
                    clear_wins    = 1'b1;
                end
            end
            GS_COUNTDOWN: begin
                if (cd_expired) state_d = GS_FIGHT;
            end
            GS_FIGHT: begin
                ko_any = p1_ko | p2_ko;
                if (p1_ko && p2_ko) begin
                    state_d = GS_KO;
                end else if (p2_ko) begin
                    state_d = GS_KO;
                    p1_inc  = 1'b1;
                end else if (p1_ko) begin
                    state_d = GS_KO;
                    p2_inc  = 1'b1;
                end else if (rt_expired) begin
                    state_d = GS_KO;
                    p1_inc  = (player1_health > player2_health);
                    p2_inc  = (player2_health > player1_health);
                end
            end
            GS_KO: begin
                if (ko_cnt == KO_LAST) begin
                    if (p1_wins == WINS_TARGET) begin
                        state_d    = GS_MATCH_OVER;
                        set_winner = 1'b1;
                        winner_d   = WIN_P1;
                    end else if (p2_wins == WINS_TARGET) begin
                        state_d    = GS_MATCH_OVER;
                        set_winner = 1'b1;
                        winner_d   = WIN_P2;
                    end else begin
                        state_d       = GS_COUNTDOWN;
                        round_reset_d = 1'b1;
                    end
                end
            end
            default: state_d = GS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= GS_IDLE;
            freeze      <= 1'b1;
            round_reset <= 1'b0;
            start_q     <= 1'b0;
            ko_cnt      <= '0;
            p1_wins     <= '0;
            p2_wins     <= '0;
            winner_q    <= WIN_NONE;
        end else begin
            state_q     <= state_d;
            freeze      <= (state_d != GS_FIGHT);
            round_reset <= round_reset_d;
            start_q     <= start;
            ko_cnt      <= (state_q == GS_KO) ? ko_cnt + KO_W'(1) : '0;
            if (clear_wins) begin
                p1_wins <= '0;
                p2_wins <= '0;
            end else begin
                if (p1_inc && (p1_wins != 2'd3)) p1_wins <= p1_wins + 2'd1;
                if (p2_inc && (p2_wins != 2'd3)) p2_wins <= p2_wins + 2'd1;
            end
            if (clear_wins)      winner_q <= WIN_NONE;
            else if (set_winner) winner_q <= winner_d;
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed match walk-through with literal
// expectations, then randomized play against a phase/elapsed-frame model.
module tb_match_controller;

    localparam int FPS    = 4;
    localparam int CD     = 3;
    localparam int RS     = 5;
    localparam int KO_FR  = 5;
    localparam int RTW    = 2;
`ifdef MATCH_ROUND_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] p1h = 3'd7;
    logic [2:0] p2h = 3'd7;
    logic [2:0] game_state;
    logic       freeze, round_reset;
    logic [3:0] countdown_digit;
    logic [6:0] round_timer;
    logic [1:0] p1_wins, p2_wins, winner;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: current phase, frames elapsed in that phase, visible outputs.
    int m_state, m_t, m_p1w, m_p2w, m_winner, m_timer, m_digit;
    bit m_rr, m_sq;

    always #5 clk = ~clk;

    match_controller #(
        .FRAMES_PER_SEC(FPS), .COUNTDOWN_SECONDS(CD), .ROUND_SECONDS(RS),
        .KO_FRAMES(KO_FR), .ROUNDS_TO_WIN(RTW), .HEALTH_W(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .player1_health(p1h), .player2_health(p2h),
        .game_state(game_state), .freeze(freeze), .round_reset(round_reset),
        .countdown_digit(countdown_digit), .round_timer(round_timer),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .winner(winner)
    );

    function automatic int inc_sat(int v);
        return (v < 3) ? v + 1 : 3;
    endfunction

    task automatic model_step();
        bit edge_s;
        if (rst) begin
            m_state = 0; m_t = 0; m_p1w = 0; m_p2w = 0; m_winner = 0;
            m_timer = 0; m_digit = 0; m_rr = 0; m_sq = 0;
        end else begin
            edge_s = start && !m_sq;
            m_sq   = start;
            m_rr   = 0;
            case (m_state)
                0, 4: if (edge_s) begin
                    m_state = 1; m_t = 0; m_p1w = 0; m_p2w = 0; m_winner = 0;
                    m_rr = 1; m_digit = CD;
                end
                1: begin
                    m_t++;
                    if (m_t == CD * FPS) begin
                        m_state = 2; m_t = 0; m_digit = 0;
                        if (TIMER_EN) m_timer = RS;
                    end else begin
                        m_digit = CD - m_t / FPS;
                    end
                end
                2: begin
                    if (p1h == 0 && p2h == 0) begin
                        m_state = 3; m_t = 0;
                    end else if (p2h == 0) begin
                        m_state = 3; m_t = 0; m_p1w = inc_sat(m_p1w);
                    end else if (p1h == 0) begin
                        m_state = 3; m_t = 0; m_p2w = inc_sat(m_p2w);
                    end else if (TIMER_EN && m_t == RS * FPS - 1) begin
                        m_state = 3; m_t = 0; m_timer = 0;
                        if (p1h > p2h) m_p1w = inc_sat(m_p1w);
                        else if (p2h > p1h) m_p2w = inc_sat(m_p2w);
                    end else begin
                        m_t++;
                        if (TIMER_EN) m_timer = RS - m_t / FPS;
                    end
                end
                3: begin
                    m_t++;
                    if (m_t == KO_FR) begin
                        if (m_p1w == RTW) begin
                            m_state = 4; m_winner = 1;
                        end else if (m_p2w == RTW) begin
                            m_state = 4; m_winner = 2;
                        end else begin
                            m_state = 1; m_t = 0; m_digit = CD; m_rr = 1;
                        end
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic check_cycle();
        n_checks++;
        if (game_state !== 3'(m_state) || freeze !== (m_state != 2) ||
            round_reset !== m_rr || countdown_digit !== 4'(m_digit) ||
            round_timer !== 7'(m_timer) || p1_wins !== 2'(m_p1w) ||
            p2_wins !== 2'(m_p2w) || winner !== 2'(m_winner)) begin
            n_errors++;
            $display("FAIL model cycle %0d: got st=%0d frz=%0d rr=%0d dig=%0d tmr=%0d w=%0d/%0d win=%0d want st=%0d frz=%0d rr=%0d dig=%0d tmr=%0d w=%0d/%0d win=%0d",
                     cyc, game_state, freeze, round_reset, countdown_digit, round_timer,
                     p1_wins, p2_wins, winner, m_state, (m_state != 2), m_rr, m_digit,
                     m_timer, m_p1w, m_p2w, m_winner);
        end
    endtask

    task automatic check_lit(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic run_to(input int st, input int budget);
        int n = 0;
        while (m_state != st && n < budget) begin
            tick();
            n++;
        end
        check_lit("run_to_state", m_state, st);
    endtask

    initial begin
        rst = 1; tick(); tick();
        check_lit("reset_state", game_state, 0);
        check_lit("reset_freeze", freeze, 1);
        check_lit("reset_rr", round_reset, 0);
        check_lit("reset_p1w", p1_wins, 0);
        rst = 0; tick();

        start = 1; tick();
        check_lit("start_rr", round_reset, 1);
        check_lit("start_state", game_state, 1);
        check_lit("start_digit", countdown_digit, 3);
        repeat (11) tick();
        check_lit("cd_last_state", game_state, 1);
        check_lit("cd_last_digit", countdown_digit, 1);
        tick();
        check_lit("fight_state", game_state, 2);
        check_lit("fight_freeze", freeze, 0);
        check_lit("fight_rr", round_reset, 0);

        p2h = 0; tick(); p2h = 7;
        check_lit("ko_state", game_state, 3);
        check_lit("ko_p1w", p1_wins, 1);
        check_lit("ko_freeze", freeze, 1);
        repeat (4) tick();
        check_lit("ko_hold_state", game_state, 3);
        tick();
        check_lit("ko_exit_rr", round_reset, 1);
        check_lit("ko_exit_state", game_state, 1);

        repeat (12) tick();
        p2h = 0; tick(); p2h = 7;
        check_lit("ko2_p1w", p1_wins, 2);
        repeat (5) tick();
        check_lit("mo_state", game_state, 4);
        check_lit("mo_winner", winner, 1);
        check_lit("mo_p1w", p1_wins, 2);
        repeat (3) tick();
        check_lit("mo_hold_state", game_state, 4);
        start = 0; tick(); start = 1; tick();
        check_lit("restart_state", game_state, 1);
        check_lit("restart_p1w", p1_wins, 0);
        check_lit("restart_winner", winner, 0);
        check_lit("restart_rr", round_reset, 1);

        repeat (12) tick();
        p1h = 0; p2h = 0; tick();
        check_lit("dko_state", game_state, 3);
        check_lit("dko_p1w", p1_wins, 0);
        check_lit("dko_p2w", p2_wins, 0);

        p1h = 5; p2h = 3;
        repeat (5) tick();
        repeat (12) tick();
        check_lit("to_fight", game_state, 2);
        repeat (20) tick();
`ifdef MATCH_ROUND_TIMER_EN
        check_lit("to_state", game_state, 3);
        check_lit("to_timer", round_timer, 0);
        check_lit("to_p1w", p1_wins, 1);
        run_to(2, 40);
`else
        check_lit("no_to_state", game_state, 2);
        check_lit("no_to_timer", round_timer, 0);
`endif
        rst = 1; tick(); rst = 0;
        check_lit("midrst_state", game_state, 0);
        check_lit("midrst_freeze", freeze, 1);
        check_lit("midrst_p1w", p1_wins, 0);
        check_lit("midrst_rr", round_reset, 0);

        for (int seg = 0; seg < 16; seg++) begin
            int rate;
            rate = (seg % 2 == 1) ? 64 : 12;
            repeat (200) begin
                p1h = ($urandom_range(0, rate - 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                p2h = ($urandom_range(0, rate - 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                if ($urandom_range(0, 7) == 0) start = ~start;
                rst = ($urandom_range(0, 499) == 0);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Round/match sequencer that sits directly downstream of health_status. It consumes both players' health and decides when a round starts, when it ends (KO or time-out), and who won.
- Its outputs freeze the players, pulse a round reset into player/health_status, and drive the HUD: countdown digit, round timer, win counts and winner.
- Clocked by the per-frame effective clock, so one clk edge equals one game frame.

Parameters:
- FRAMES_PER_SEC, 60, frames per displayed second (countdown and round timer).
- COUNTDOWN_SECONDS, 3, pre-fight countdown length in seconds (1..9).
- ROUND_SECONDS, 99, round time limit in seconds (1..99).
- KO_FRAMES, 120, frames held in KO state before the next round or match end.
- ROUNDS_TO_WIN, 2, round wins needed to take the match (1..3).
- HEALTH_W, 3, width of the health inputs.

Ports:
- clk  in  1  frame clock (effective_clk)
- rst  in  1  synchronous, active-high reset
- start  in  1  level start request (debounced key); internally rising-edge detected
- player1_health  in  HEALTH_W  P1 health from health_status; 0 = KO
- player2_health  in  HEALTH_W  P2 health from health_status; 0 = KO
- game_state  out  3  IDLE=0, COUNTDOWN=1, FIGHT=2, KO=3, MATCH_OVER=4
- freeze  out  1  1 = players ignore controls
- round_reset  out  1  one-cycle pulse: reset player positions/health
- countdown_digit  out  4  remaining countdown seconds (COUNTDOWN only, else 0)
- round_timer  out  7  remaining round seconds
- p1_wins  out  2  rounds won by P1
- p2_wins  out  2  rounds won by P2
- winner  out  2  0 none/draw, 1 P1, 2 P2; valid in MATCH_OVER

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: game_state=IDLE, freeze=1, round_reset=0, countdown_digit=0, round_timer=0, p1_wins=0, p2_wins=0, winner=0, start-edge register=0.
- All outputs are registered.
- Start edge: start_edge = start & ~start_q, where start_q is registered each cycle.
- IDLE:
  - freeze=1.
  - On start_edge: next cycle state=COUNTDOWN, round_reset=1 for exactly that cycle, wins cleared, winner=0.
- COUNTDOWN:
  - freeze=1; health inputs are ignored.
  - On entry: frame counter=0 and countdown_digit=COUNTDOWN_SECONDS.
  - When frame counter reaches FRAMES_PER_SEC-1 it wraps to 0 and the digit decrements.
  - When the digit is 1 and the counter wraps: state=FIGHT, countdown_digit=0, round_timer=ROUND_SECONDS, frame counter=0.
  - Total duration: COUNTDOWN_SECONDS*FRAMES_PER_SEC cycles.
- FIGHT: freeze=0. Each cycle, evaluated in priority order:
  1. Both health==0: draw, no win increment, go to KO.
  2. p2 health==0: p1_wins+1, go to KO.
  3. p1 health==0: p2_wins+1, go to KO.
  4. Timer expiry (round_timer==1 and frame wrap): round_timer=0. Higher health wins (+1 to that player); equal health is a draw. Go to KO.
  - KO checks take precedence over a simultaneous timer expiry.
- KO:
  - freeze=1; counts KO_FRAMES cycles.
  - On the last cycle, if p1_wins==ROUNDS_TO_WIN or p2_wins==ROUNDS_TO_WIN: go to MATCH_OVER with winner=1 or 2 accordingly.
  - Otherwise: go to COUNTDOWN with a round_reset pulse on the entry cycle.
- MATCH_OVER:
  - freeze=1; winner and wins are held.
  - On start_edge: behave as IDLE start (clear, round_reset, COUNTDOWN).
- start_edge is ignored in COUNTDOWN, FIGHT and KO.
- Win counters saturate at 3.
- Reset mid-round returns every output to its reset value on the next edge.
- No round_reset pulse is issued on rst itself.

Optional Feature:
- Macro: MATCH_ROUND_TIMER_EN.
- Defined: round timer runs as described; time-out ends the round.
- Not defined: the round timer logic is absent and round_timer is tied to 0. FIGHT ends only by KO. The draw case arises only from a simultaneous double KO.

Decomposition:
- demoman_pkg holds:
  - the game_state encodings (IDLE..MATCH_OVER);
  - the winner encodings (NONE, P1, P2);
  - the HEALTH_W default.
- Sub-module sec_timer (frame counter plus seconds down-counter, load/enable/expired) is instantiated twice: once for the countdown and once for the round timer. The round-timer instance sits under MATCH_ROUND_TIMER_EN.

Test Plan (FRAMES_PER_SEC=4, COUNTDOWN_SECONDS=3, ROUND_SECONDS=5, KO_FRAMES=5, ROUNDS_TO_WIN=2):
- Start from IDLE: rst, then start 0->1 -> round_reset=1 for one cycle; game_state=1 with digit 3,3,3,3,2,..,1. game_state=2 after 12 cycles; freeze drops to 0.
- KO: in FIGHT, drive p2_health=0 -> next cycle game_state=3, p1_wins=1, freeze=1. After 5 cycles round_reset pulses and game_state=1.
- Match end: P1 wins a second round -> after KO_FRAMES, game_state=4, winner=1, p1_wins=2. Holding start high gives no restart; a new edge restarts with wins=0.
- Double KO: both health 0 in the same cycle -> KO, no win increment.
- Time-out (macro defined): healths 5 and 3, no KO -> after 20 FIGHT cycles round_timer=0, p1_wins+1. With equal health, a draw. With the macro undefined, round_timer=0 and FIGHT persists.
- Reset mid-FIGHT: rst=1 for one cycle -> game_state=0, freeze=1, wins=0, no round_reset pulse.
